adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter n, default 64: operand width in bits.
REQ-002 Parameter NREQ, default 4, legal range 2..4: number of requesters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  one-hot accept strobe to granted requester.
REQ-007 req_X  input  NREQ*n  operand X; requester k occupies bits [k*n +: n].
REQ-008 req_Y  input  NREQ*n  operand Y; same packing as req_X.
REQ-009 req_cin  input  NREQ  carry-in per requester.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 resp_id  output  2  index of the requester that owns the result.
REQ-013 result  output  n+1  sum X+Y+cin; bit n is carry-out.

Function
REQ-014 Block shall time-share one n-bit carry-lookahead adder among NREQ requesters, using a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid bit is high, pick a winner, assert its req_ready bit combinationally in that cycle, latch X/Y/cin/id on the edge, and go to EXEC; otherwise stay in IDLE.
REQ-016 req_ready shall be zero in EXEC and RESP; at most one bit is set in any cycle.
REQ-017 Requesters shall hold req_valid and operands stable until req_ready; deasserting req_valid before grant withdraws the request with no side effects.
REQ-018 Round-robin: search starts at last_grant+1 modulo NREQ, wraps, and picks the first valid; last_grant updates only on grant.
REQ-019 EXEC: drive the latched operands into the adder, register the n+1-bit sum into result on the edge, and go to RESP.
REQ-020 RESP: resp_valid=1 with result/resp_id stable; on resp_valid&resp_ready, go to IDLE; otherwise hold (backpressure, unbounded).
REQ-021 Latency: grant edge to resp_valid = 2 cycles; minimum spacing between grants = 3 cycles.
REQ-022 result shall be the exact unsigned sum; all-ones+all-ones+1 gives result = {1, all-ones}.
REQ-023 Requests arriving in EXEC/RESP are not lost; they are arbitrated on the next IDLE cycle.

Reset
REQ-024 rst shall force state=IDLE, resp_valid=0, req_ready=0, result=0, resp_id=0, and last_grant=NREQ-1, so requester 0 has first priority.
REQ-025 rst asserted in EXEC or RESP shall discard the in-flight operation; no response is produced for it.
REQ-026 rst shall override any simultaneous grant or resp_ready in the same cycle.

Configuration
REQ-027 Macro ADDER_ARB_PRIO0_EN: when defined, requester 0 wins whenever its req_valid is high, and the other requesters use round-robin among themselves; last_grant is not updated by requester-0 grants.
REQ-028 Without ADDER_ARB_PRIO0_EN: pure round-robin per REQ-018 over all NREQ requesters.

Verification
REQ-029 Single request: req0 X=5, Y=7, cin=1 -> req_ready[0] pulse, then 2 cycles later resp_valid=1, result=13, resp_id=0.
REQ-030 All 4 requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles (without PRIO0).
REQ-031 Overflow: X=Y=2^64-1, cin=1 -> result=2^65-1 (bit 64 set, low 64 bits all ones).
REQ-032 resp_ready=0 for 10 cycles while req1 is valid -> resp_valid and result stay stable, no req_ready; one cycle after resp_ready=1, req1 is granted.
REQ-033 rst pulsed in EXEC -> next cycle resp_valid=0 and state IDLE; the pending request is re-granted starting from requester 0.
REQ-034 PRIO0_EN build, requesters 0 and 2 continuously valid -> requester 0 wins every grant.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one Kogge-Stone carry-lookahead adder among NREQ requesters.
// Optional build macro ADDER_ARB_PRIO0_EN gives requester 0 fixed priority over the round-robin group.
module adder_arbiter #(
   parameter int n    = 64,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*n-1:0] req_X,
   input  logic [NREQ*n-1:0] req_Y,
   input  logic [NREQ-1:0]   req_cin,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [1:0]        resp_id,
   output logic [n:0]        result
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state_q, state_d;
   logic [1:0]   last_grant_q, last_grant_d;
   logic [1:0]   id_q, id_d;
   logic [n:0]   result_q, result_d;
   logic [n-1:0] x_q, x_d, y_q, y_d;
   logic         cin_q, cin_d;

   logic         grant_vld;
   logic [1:0]   grant_idx;
   logic         take;

   // Parallel-prefix add: cin folds into bit 0 generate, so every carry comes out of the prefix tree.
   function automatic logic [n:0] cla_add(input logic [n-1:0] a, input logic [n-1:0] b,
                                          input logic c);
      logic [n-1:0] t, gg, pp;
      t     = a ^ b;
      gg    = a & b;
      pp    = t;
      gg[0] = gg[0] | (t[0] & c);
      for (int d = 1; d < n; d = d * 2) begin
         for (int i = n - 1; i >= d; i--) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      return {gg[n-1], t ^ {gg[n-2:0], c}};
   endfunction

   always_comb begin
      logic [1:0] idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = '0;
`ifdef ADDER_ARB_PRIO0_EN
      if (req_valid[0]) begin
         grant_vld = 1'b1;
         grant_idx = '0;
      end
`endif
      // Search from last_grant+1, wrapping; first valid requester wins.
      for (int off = 1; off <= NREQ; off++) begin
         idx = 2'((int'(last_grant_q) + off) % NREQ);
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

   assign take = (state_q == IDLE) && grant_vld && !rst;

   always_comb begin
      req_ready = '0;
      if (take) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      result_d     = result_q;
      x_d          = x_q;
      y_d          = y_q;
      cin_d        = cin_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               x_d     = req_X[int'(grant_idx)*n +: n];
               y_d     = req_Y[int'(grant_idx)*n +: n];
               cin_d   = req_cin[grant_idx];
               id_d    = grant_idx;
               state_d = EXEC;
`ifdef ADDER_ARB_PRIO0_EN
               if (grant_idx != 2'd0) last_grant_d = grant_idx;
`else
               last_grant_d = grant_idx;
`endif
            end
         end
         EXEC: begin
            result_d = cla_add(x_q, y_q, cin_q);
            state_d  = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 2'(NREQ - 1);
         id_q         <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         result_q     <= result_d;
      end
   end

   // Operand holding registers are pure data and carry no reset.
   always_ff @(posedge clk) begin
      x_q   <= x_d;
      y_q   <= y_d;
      cin_q <= cin_d;
   end

   assign resp_valid = (state_q == RESP);
   assign resp_id    = id_q;
   assign result     = result_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, single op, overflow, round-robin order, backpressure, reset in EXEC.
module tb_adder_arbiter;

  localparam int n    = 64;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*n-1:0] req_X;
  logic [NREQ*n-1:0] req_Y;
  logic [NREQ-1:0]   req_cin;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [n:0]        result;

  int n_chk  = 0;
  int n_fail = 0;

  adder_arbiter #(.n(n), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_X      (req_X),
    .req_Y      (req_Y),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [n:0] obs, input logic [n:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [1:0]  order   [5];
    logic [n:0]  exp_sum [4];
    logic [n:0]  held;
    logic [n:0]  big;

`ifdef ADDER_ARB_PRIO0_EN
    order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    // Xk = 100k, Yk = k+1, cin = 4'b1010
    exp_sum = '{65'd1, 65'd103, 65'd203, 65'd305};
    big     = {1'b1, {n{1'b1}}};

    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_X      = '0;
    req_Y      = '0;
    req_cin    = '0;
    resp_ready = 1'b1;

    // Reset state, with requests present
    cyc();
    cyc();
    settle();
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_result", result, 65'd0);
    chk("rst_resp_id", resp_id, 2'd0);
    req_valid = '0;
    cyc();
    rst = 1'b0;

    // Single request: 5 + 7 + 1
    req_X[0 +: n] = 64'd5;
    req_Y[0 +: n] = 64'd7;
    req_cin       = 4'b0001;
    req_valid     = 4'b0001;
    settle();
    chk("single_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    settle();
    chk("single_exec_ready", req_ready, 4'b0000);
    chk("single_exec_valid", resp_valid, 1'b0);
    cyc();
    settle();
    chk("single_resp_valid", resp_valid, 1'b1);
    chk("single_result", result, 65'd13);
    chk("single_resp_id", resp_id, 2'd0);
    cyc();
    settle();
    chk("single_idle", resp_valid, 1'b0);

    // Overflow on requester 2
    req_X[2*n +: n] = {n{1'b1}};
    req_Y[2*n +: n] = {n{1'b1}};
    req_cin         = 4'b0100;
    req_valid       = 4'b0100;
    settle();
    chk("ovf_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    cyc();
    settle();
    chk("ovf_result", result, big);
    chk("ovf_resp_id", resp_id, 2'd2);
    cyc();

    // Round-robin with all requesters valid, from a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_X[k*n +: n] = 64'(100 * k);
      req_Y[k*n +: n] = 64'(k + 1);
    end
    req_cin   = 4'b1010;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      settle();
      chk("rr_grant", req_ready, 4'(1) << order[g]);
      cyc();
      settle();
      chk("rr_exec_ready", req_ready, 4'b0000);
      cyc();
      settle();
      chk("rr_resp_valid", resp_valid, 1'b1);
      chk("rr_resp_id", resp_id, order[g]);
      chk("rr_result", result, exp_sum[order[g]]);
      cyc();
    end
    req_valid = '0;

    // Backpressure: response held while requester 1 waits
    req_X[0 +: n] = 64'd5;
    req_Y[0 +: n] = 64'd7;
    req_cin       = 4'b0000;
    req_valid     = 4'b0001;
    settle();
    chk("bp_grant0", req_ready, 4'b0001);
    cyc();
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    settle();
    chk("bp_exec_ready", req_ready, 4'b0000);
    cyc();
    held = 65'd12;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_result", result, held);
      chk("bp_hold_ready", req_ready, 4'b0000);
      cyc();
    end
    resp_ready = 1'b1;
    settle();
    chk("bp_release_ready", req_ready, 4'b0000);
    cyc();
    settle();
    chk("bp_grant1", req_ready, 4'b0010);
    chk("bp_idle_valid", resp_valid, 1'b0);

    // Reset while in EXEC discards the operation; priority restarts at requester 0
    cyc();
    req_valid = 4'b0011;
    rst       = 1'b1;
    settle();
    chk("rx_rst_ready", req_ready, 4'b0000);
    cyc();
    rst = 1'b0;
    settle();
    chk("rx_resp_valid", resp_valid, 1'b0);
    chk("rx_regrant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    cyc();
    settle();
    chk("rx_resp_valid2", resp_valid, 1'b1);
    chk("rx_result", result, 65'd12);
    chk("rx_resp_id", resp_id, 2'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
